// File: rtl/rnn_pkg.sv
// rnn_pkg: shared constants and tables for the denoise gain interpolation
//   FIXED      data width (signed Q16.16)
//   NB_BANDS   band gains per frame
//   FREQ_SIZE  spectrum bins per frame
//   ONE        Q16.16 unity
//   BAND_EDGE  band start edges in units of 4 bins
//   RECIP      round(65536/band_size) per band, 0 for the final edge entry
package rnn_pkg;
  localparam int FIXED = 32;
  localparam int NB_BANDS = 22;
  localparam int FREQ_SIZE = 481;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [7:0] BAND_EDGE [22] = '{
    8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd10, 8'd12,
    8'd14, 8'd16, 8'd20, 8'd24, 8'd28, 8'd34, 8'd40, 8'd48, 8'd60, 8'd78, 8'd100
  };
  localparam logic [16:0] RECIP [22] = '{
    17'd16384, 17'd16384, 17'd16384, 17'd16384, 17'd16384, 17'd16384, 17'd16384, 17'd16384,
    17'd8192, 17'd8192, 17'd8192, 17'd8192,
    17'd4096, 17'd4096, 17'd4096,
    17'd2731, 17'd2731, 17'd2048, 17'd1365, 17'd910, 17'd745, 17'd0
  };
  function automatic logic [9:0] band_start(input logic [4:0] b);
    return {BAND_EDGE[b], 2'b00};
  endfunction
endpackage

// File: rtl/gain_interp_mul.sv
// q16_mul: combinational signed Q16.16 multiply returning product bits [W+W/2-1:W/2]
//   a, b  W-bit signed operands
//   p     W-bit truncated product, no saturation
module q16_mul #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);
  logic signed [2*W-1:0] w_prod;
  assign w_prod = (2*W)'($signed(a)) * (2*W)'($signed(b));
  assign p = W'(w_prod >>> (W/2));
endmodule

// File: rtl/gain_interp.sv
// gain_interp: scales a spectrum bin stream by per-bin gains linearly interpolated from band gains
//   clk, rst                    clock, asynchronous active-low reset
//   gain_we/gain_addr/gain_data band-gain write port, accepted only while idle
//   start                       one-cycle frame start pulse
//   in_valid/in_ready/in_re/im  input bin stream
//   out_valid/out_ready/out_*   scaled bin stream with bin index, 1-cycle latency
//   busy, done                  frame in progress, one-cycle end-of-frame pulse
module gain_interp #(
  parameter int FIXED = rnn_pkg::FIXED,
  parameter int NB_BANDS = rnn_pkg::NB_BANDS,
  parameter int FREQ_SIZE = rnn_pkg::FREQ_SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gain_we,
  input  logic [4:0]       gain_addr,
  input  logic [FIXED-1:0] gain_data,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FIXED-1:0] in_re,
  input  logic [FIXED-1:0] in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FIXED-1:0] out_re,
  output logic [FIXED-1:0] out_im,
  output logic [8:0]       out_idx,
  output logic             busy,
  output logic             done
);
  import rnn_pkg::*;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  logic [1:0] r_state;
  logic [8:0] r_bin;
  logic [4:0] r_band;
  logic [16:0] r_frac;
  logic [FIXED-1:0] r_gain [NB_BANDS];
  logic w_acc, w_last, w_edge, w_hi, w_take;
  logic [4:0] w_nb;
  logic [9:0] w_nxt;
  logic [FIXED-1:0] w_g0, w_g1, w_diff, w_step, w_gain, w_re, w_im;
  assign busy = r_state != S_IDLE;
  assign in_ready = r_state == S_RUN && (!out_valid || out_ready);
  assign w_acc = in_valid && in_ready;
  assign w_take = r_state == S_FLUSH && out_valid && out_ready;
  assign w_last = r_bin == 9'(FREQ_SIZE-1);
  assign w_nb = r_band + 5'd1;
  assign w_nxt = {1'b0, r_bin} + 10'd1;
  // the last interpolating band never advances, so g[i+1] stays within the file
  assign w_edge = w_nxt == band_start(w_nb) && 32'(r_band) < NB_BANDS-2;
  // bins past the final band edge carry no gain
  assign w_hi = {1'b0, r_bin} >= band_start(5'(NB_BANDS-1));
  assign w_g0 = r_gain[r_band];
  assign w_g1 = r_gain[w_nb];
  assign w_diff = w_g1 - w_g0;
  assign w_gain = w_hi ? '0 : w_g0 + w_step;
  q16_mul #(.W(FIXED)) u_interp (.a(w_diff), .b(FIXED'(r_frac)), .p(w_step));
  q16_mul #(.W(FIXED)) u_re (.a(in_re), .b(w_gain), .p(w_re));
  q16_mul #(.W(FIXED)) u_im (.a(in_im), .b(w_gain), .p(w_im));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_bin <= '0;
      r_band <= '0;
      r_frac <= '0;
      done <= 1'b0;
    end else begin
      done <= w_take;
      if (r_state == S_IDLE && start) begin
        r_state <= S_RUN;
        r_bin <= '0;
        r_band <= '0;
        r_frac <= '0;
      end else if (w_acc) begin
        r_bin <= r_bin + 9'd1;
        r_band <= w_edge ? w_nb : r_band;
        r_frac <= w_edge ? '0 : r_frac + RECIP[r_band];
        r_state <= w_last ? S_FLUSH : S_RUN;
      end else if (w_take) begin
        r_state <= S_IDLE;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NB_BANDS; k++) r_gain[k] <= '0;
    end else if (gain_we && !busy && 32'(gain_addr) < NB_BANDS) begin
      r_gain[gain_addr] <= gain_data;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_re <= '0;
      out_im <= '0;
      out_idx <= '0;
    end else if (w_acc) begin
      out_valid <= 1'b1;
      out_re <= w_re;
      out_im <= w_im;
      out_idx <= r_bin;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_gain_interp.sv
// tb_gain_interp: directed self-checking bench for gain_interp
module tb_gain_interp;
  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam logic [31:0] NEG = 32'hFFFF_0000;
  logic clk = 1'b0;
  logic rst, gain_we, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [4:0] gain_addr;
  logic [31:0] gain_data, in_re, in_im, out_re, out_im;
  logic [8:0] out_idx;
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [31:0] exp_re [481];
  logic [31:0] exp_im [481];
  bit known [481];
  gain_interp dut (
    .clk(clk), .rst(rst), .gain_we(gain_we), .gain_addr(gain_addr), .gain_data(gain_data),
    .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    gain_we = 1'b1;
    gain_addr = a;
    gain_data = d;
    @(negedge clk);
    gain_we = 1'b0;
  endtask
  task automatic set_all(input logic [31:0] d);
    for (int i = 0; i < 22; i++) wr(5'(i), d);
  endtask
  task automatic fill_const(input logic [31:0] g);
    for (int k = 0; k < 481; k++) begin
      known[k] = 1'b1;
      exp_re[k] = (k < 400) ? g : 32'h0;
      exp_im[k] = (k < 400) ? -g : 32'h0;
    end
  endtask
  task automatic fill_interp();
    logic [31:0] v [5];
    v = '{32'h0, 32'h4000, 32'h8000, 32'hC000, 32'h800C};
    for (int k = 0; k < 481; k++) begin
      known[k] = k >= 400;
      exp_re[k] = 32'h0;
      exp_im[k] = 32'h0;
    end
    for (int k = 0; k < 5; k++) begin
      known[k < 4 ? k : 356] = 1'b1;
      exp_re[k < 4 ? k : 356] = v[k];
      exp_im[k < 4 ? k : 356] = -v[k];
    end
  endtask
  task automatic run_frame(input int stall_bin, input int inj_bin, input int rst_bin);
    int idx, cyc, d0;
    bit st_done, inj_done;
    logic [31:0] h_re, h_im;
    logic [8:0] h_idx;
    idx = 0;
    cyc = 0;
    st_done = 0;
    inj_done = 0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    in_re = ONE;
    in_im = NEG;
    in_valid = 1'b1;
    out_ready = 1'b1;
    while (idx < 481 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      gain_we = 1'b0;
      if (rst_bin >= 0 && out_valid && out_idx == 9'(rst_bin)) begin
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_re", out_re, 32'h0);
        chk("rst_out_im", out_im, 32'h0);
        chk("rst_out_idx", 32'(out_idx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_no_done", 32'(done_cnt - d0), 32'h0);
        return;
      end
      if (stall_bin >= 0 && !st_done && out_valid && out_idx == 9'(stall_bin)) begin
        st_done = 1;
        out_ready = 1'b0;
        h_re = out_re;
        h_im = out_im;
        h_idx = out_idx;
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 32'(out_valid), 32'h1);
          chk("stall_idx", 32'(out_idx), 32'(h_idx));
          chk("stall_re", out_re, h_re);
          chk("stall_im", out_im, h_im);
          chk("stall_in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
      end
      if (inj_bin >= 0 && !inj_done && out_valid && out_idx == 9'(inj_bin)) begin
        inj_done = 1;
        start = 1'b1;
        gain_we = 1'b1;
        gain_addr = 5'd15;
        gain_data = 32'h0;
      end
      if (out_valid && out_ready) begin
        chk("out_idx", 32'(out_idx), 32'(idx));
        if (known[idx]) begin
          chk($sformatf("re[%0d]", idx), out_re, exp_re[idx]);
          chk($sformatf("im[%0d]", idx), out_im, exp_im[idx]);
        end
        idx++;
      end
    end
    chk("frame_bins", 32'(idx), 32'd481);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt - d0), 32'h1);
    chk("idle_busy", 32'(busy), 32'h0);
  endtask
  initial begin
    rst = 1'b0;
    gain_we = 1'b0;
    gain_addr = '0;
    gain_data = '0;
    start = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_re = '0;
    in_im = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_re", out_re, 32'h0);
    chk("reset_out_im", out_im, 32'h0);
    chk("reset_out_idx", 32'(out_idx), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_in_ready", 32'(in_ready), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    set_all(ONE);
    fill_const(ONE);
    run_frame(-1, -1, -1);
    set_all(32'h0);
    wr(5'd1, ONE);
    wr(5'd21, ONE);
    fill_interp();
    run_frame(-1, -1, -1);
    set_all(ONE);
    fill_const(ONE);
    run_frame(10, -1, -1);
    run_frame(-1, 100, -1);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, 200);
    fill_const(32'h0);
    run_frame(-1, -1, -1);
    set_all(ONE);
    fill_const(ONE);
    run_frame(-1, -1, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
